// File: rtl/regfile_dump_pkg.sv
// Shared debug-side definitions for the register-file dumper.
// The defaults are also used by the register file and the debug unit.
package regfile_dump_pkg;

  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_DATA_W   = 32;

  function automatic int bytes_per_word(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int byte_idx_width(input int data_w);
    return (data_w / 8 > 1) ? $clog2(data_w / 8) : 1;
  endfunction

  localparam int BYTES_PER_WORD = bytes_per_word(DEF_DATA_W);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SEND   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

endpackage

// File: rtl/regfile_dump_if.sv
// Register-file read port plus UART TX start/done handshake.
// The dumper is the master; the register file and the UART sit on the slave side.
interface regfile_dump_if
  import regfile_dump_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy;
  logic              tx_done;

  modport master (
    output rd_addr,
    output tx_data,
    output tx_start,
    input  rd_data,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  rd_addr,
    input  tx_data,
    input  tx_start,
    output rd_data,
    output tx_busy,
    output tx_done
  );

endinterface

// File: rtl/regfile_dump_word_serializer.sv
// Holds one captured register word and presents it byte by byte.
// byte_idx restarts on every load; last flags the final byte of the word.
module regfile_dump_word_serializer
  import regfile_dump_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] word,
  input  logic              advance,
  output logic [7:0]        byte_sel,
  output logic              last
);

  localparam int BYTES  = bytes_per_word(DATA_W);
  localparam int BIDX_W = byte_idx_width(DATA_W);
  localparam logic [BIDX_W-1:0] LAST_IDX = BIDX_W'(BYTES - 1);

  logic [DATA_W-1:0] word_reg;
  logic [BIDX_W-1:0] byte_idx_reg;
  logic [7:0]        lane [BYTES];

  // Lane k is the k-th byte on the wire, so the selector is order-agnostic.
  generate
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
      if (MSB_FIRST != 0) begin : g_msb
        assign lane[gi] = word_reg[DATA_W-1-8*gi -: 8];
      end else begin : g_lsb
        assign lane[gi] = word_reg[8*gi +: 8];
      end
    end
  endgenerate

  always_comb begin
    byte_sel = lane[byte_idx_reg];
  end

  assign last = (byte_idx_reg == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rst) begin
      word_reg     <= '0;
      byte_idx_reg <= '0;
    end else if (load) begin
      word_reg     <= word;
      byte_idx_reg <= '0;
    end else if (advance) begin
      byte_idx_reg <= byte_idx_reg + BIDX_W'(1);
    end
  end

endmodule

// File: rtl/regfile_dump.sv
// Walks every register-file address and streams each word to the UART,
// one byte per start/done handshake, while the pipeline is halted.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int NUM_REGS  = DEF_NUM_REGS,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MSB_FIRST = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           busy,
  output logic           done,
  regfile_dump_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

  state_t            state_reg;
  logic [ADDR_W-1:0] reg_idx_reg;
  logic [7:0]        tx_data_reg;
  logic              tx_start_reg;
  logic              busy_reg;
  logic              done_reg;

  logic              load;
  logic              advance;
  logic              last_byte;
  logic [7:0]        cur_byte;

  assign load    = (state_reg == ST_LOAD);
  assign advance = (state_reg == ST_WAIT) && bus.tx_done && !last_byte;

  regfile_dump_word_serializer #(
    .DATA_W    (DATA_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_serializer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .word     (bus.rd_data),
    .advance  (advance),
    .byte_sel (cur_byte),
    .last     (last_byte)
  );

  // The register index doubles as the read address, so rd_addr is registered.
  assign bus.rd_addr  = reg_idx_reg;
  assign bus.tx_data  = tx_data_reg;
  assign bus.tx_start = tx_start_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      reg_idx_reg  <= '0;
      tx_data_reg  <= '0;
      tx_start_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      tx_start_reg <= 1'b0;
      done_reg     <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            reg_idx_reg <= '0;
            busy_reg    <= 1'b1;
            state_reg   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          state_reg <= ST_SEND;
        end
        ST_SEND: begin
          if (!bus.tx_busy) begin
            tx_data_reg  <= cur_byte;
            tx_start_reg <= 1'b1;
            state_reg    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Terminal compares come first, so neither counter ever wraps.
          if (bus.tx_done) begin
            if (!last_byte) begin
              state_reg <= ST_SEND;
            end else if (reg_idx_reg < LAST_REG) begin
              reg_idx_reg <= reg_idx_reg + ADDR_W'(1);
              state_reg   <= ST_LOAD;
            end else begin
              done_reg  <= 1'b1;
              state_reg <= ST_FINISH;
            end
          end
        end
        ST_FINISH: begin
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Randomized bench for regfile_dump: two instances (MSB-first and LSB-first),
// a register-file array, a UART TX responder and a byte-stream reference model.
module tb_regfile_dump;

  bit clk = 1'b0;
  bit rst = 1'b0;
  always #5 clk = ~clk;

  bit   start_v [2];
  logic busy_w  [2];
  logic done_w  [2];

  bit [31:0] regs [2][32];

  // TX responder state, one slot per instance (0 = MSB first, 1 = LSB first)
  bit       tx_busy_v   [2];
  bit       tx_done_v   [2];
  bit       force_busy  [2];
  bit       inject_done [2];
  bit       rand_hold   [2];
  int       fixed_hold = 10;
  int       cnt       [2];
  bit [7:0] cur       [2];
  bit [7:0] cap       [2][1024];
  int       cap_n     [2];
  int       ack_n     [2];
  int       done_n    [2];
  int       done_ack  [2];
  int       stab_err  [2];
  int       proto_err [2];

  int tests_run = 0;
  int fails     = 0;

  regfile_dump_if #(.ADDR_W(5), .DATA_W(32)) bus0 ();
  regfile_dump_if #(.ADDR_W(5), .DATA_W(32)) bus1 ();

  regfile_dump #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .MSB_FIRST(1)) dut_msb (
    .clk   (clk),
    .rst   (rst),
    .start (start_v[0]),
    .busy  (busy_w[0]),
    .done  (done_w[0]),
    .bus   (bus0)
  );

  regfile_dump #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .MSB_FIRST(0)) dut_lsb (
    .clk   (clk),
    .rst   (rst),
    .start (start_v[1]),
    .busy  (busy_w[1]),
    .done  (done_w[1]),
    .bus   (bus1)
  );

  assign bus0.rd_data = regs[0][bus0.rd_addr];
  assign bus1.rd_data = regs[1][bus1.rd_addr];
  assign bus0.tx_busy = tx_busy_v[0];
  assign bus1.tx_busy = tx_busy_v[1];
  assign bus0.tx_done = tx_done_v[0];
  assign bus1.tx_done = tx_done_v[1];

  // UART model: busy for a hold time after each tx_start, then a 1-cycle done.
  task automatic mon_step(input int w, input logic ts, input logic [7:0] td, input logic dn);
    bit dv;
    dv = 1'b0;
    if (ts === 1'b1) begin
      if (cnt[w] != 0) proto_err[w]++;
      cap[w][cap_n[w] % 1024] = td;
      cap_n[w]++;
      cur[w] = td;
      cnt[w] = rand_hold[w] ? int'($urandom_range(12, 1)) : fixed_hold;
    end else if (cnt[w] != 0) begin
      if (td !== cur[w]) stab_err[w]++;
      cnt[w]--;
      if (cnt[w] == 0) begin
        dv = 1'b1;
        ack_n[w]++;
      end
    end
    if (dn === 1'b1) begin
      done_n[w]++;
      done_ack[w] = ack_n[w];
    end
    tx_busy_v[w] = (cnt[w] != 0) || force_busy[w];
    tx_done_v[w] = dv || inject_done[w];
  endtask

  always @(negedge clk) mon_step(0, bus0.tx_start, bus0.tx_data, done_w[0]);
  always @(negedge clk) mon_step(1, bus1.tx_start, bus1.tx_data, done_w[1]);

  // Reference: byte n of a dump is byte n%4 of register n/4, in wire order.
  function automatic bit [7:0] exp_byte(input int w, input int n);
    bit [31:0] word;
    int k;
    word = regs[w][n / 4];
    k = n % 4;
    return 8'(word >> ((w == 0) ? 8 * (3 - k) : 8 * k));
  endfunction

  function automatic int stream_errs(input int w, input int base, output int first_bad);
    int e;
    e = 0;
    first_bad = -1;
    for (int n = 0; n < 128; n++) begin
      if (cap[w][(base + n) % 1024] != exp_byte(w, n)) begin
        if (first_bad < 0) first_bad = n;
        e++;
      end
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start(input int w);
    start_v[w] = 1'b1;
    tick();
    start_v[w] = 1'b0;
  endtask

  task automatic wait_done(input int w, output bit ok);
    int d0;
    d0 = done_n[w];
    for (int i = 0; i < 4000 && done_n[w] == d0; i++) tick();
    ok = (done_n[w] != d0);
    tick();
  endtask

  task automatic randomize_regs(input int w);
    for (int i = 0; i < 32; i++) regs[w][i] = $urandom;
  endtask

  task automatic test_reset();
    int c0, c1;
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    c0 = cap_n[0];
    c1 = cap_n[1];
    for (int i = 0; i < 10; i++) begin
      tick();
      tests_run++;
      if (busy_w[0] !== 1'b0 || done_w[0] !== 1'b0 || bus0.tx_start !== 1'b0 ||
          bus0.tx_data !== 8'h00 || bus0.rd_addr !== 5'd0) begin
        fails++;
        $display("FAIL reset_idle_msb cycle %0d: busy=%b done=%b tx_start=%b tx_data=%h rd_addr=%0d, required all 0",
                 i, busy_w[0], done_w[0], bus0.tx_start, bus0.tx_data, bus0.rd_addr);
      end
      tests_run++;
      if (busy_w[1] !== 1'b0 || done_w[1] !== 1'b0 || bus1.tx_start !== 1'b0 ||
          bus1.tx_data !== 8'h00 || bus1.rd_addr !== 5'd0) begin
        fails++;
        $display("FAIL reset_idle_lsb cycle %0d: busy=%b done=%b tx_start=%b tx_data=%h rd_addr=%0d, required all 0",
                 i, busy_w[1], done_w[1], bus1.tx_start, bus1.tx_data, bus1.rd_addr);
      end
    end
    tests_run++;
    if (cap_n[0] != c0 || cap_n[1] != c1) begin
      fails++;
      $display("FAIL reset_no_tx_start: saw %0d/%0d tx_start pulses, required 0", cap_n[0] - c0, cap_n[1] - c1);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_full_dump_msb();
    bit ok;
    int b, a, d, s, p, fb, errs;
    bit [7:0] first8 [8];
    bit [7:0] last4  [4];
    first8 = '{8'hA0, 8'hB0, 8'hC0, 8'h00, 8'hA0, 8'hB0, 8'hC0, 8'h01};
    last4  = '{8'hA0, 8'hB0, 8'hC0, 8'h1F};
    for (int i = 0; i < 32; i++) regs[0][i] = 32'hA0B0C000 + 32'(i);
    rand_hold[0] = 1'b0;
    b = cap_n[0]; a = ack_n[0]; d = done_n[0]; s = stab_err[0]; p = proto_err[0];
    pulse_start(0);
    tests_run++;
    if (busy_w[0] !== 1'b1) begin
      fails++;
      $display("FAIL full_busy_after_start: busy=%b required 1", busy_w[0]);
    end
    wait_done(0, ok);
    tests_run++;
    if (!ok) begin
      fails++;
      $display("FAIL full_timeout: done not seen, got %0d bytes", cap_n[0] - b);
    end
    tests_run++;
    if (cap_n[0] - b != 128) begin
      fails++;
      $display("FAIL full_byte_count: got %0d required 128", cap_n[0] - b);
    end
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (cap[0][(b + i) % 1024] != first8[i]) begin
        fails++;
        $display("FAIL full_first_bytes[%0d]: got %h required %h", i, cap[0][(b + i) % 1024], first8[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (cap[0][(b + 124 + i) % 1024] != last4[i]) begin
        fails++;
        $display("FAIL full_last_bytes[%0d]: got %h required %h", i, cap[0][(b + 124 + i) % 1024], last4[i]);
      end
    end
    tests_run++;
    if (done_n[0] - d != 1 || done_ack[0] - a != 128) begin
      fails++;
      $display("FAIL full_done_pulse: %0d pulses after %0d tx_done, required 1 after 128", done_n[0] - d, done_ack[0] - a);
    end
    errs = stream_errs(0, b, fb);
    tests_run++;
    if (errs != 0) begin
      fails++;
      $display("FAIL full_stream: %0d wrong bytes, first at %0d got %h required %h",
               errs, fb, cap[0][(b + fb) % 1024], exp_byte(0, fb));
    end
    tests_run++;
    if (stab_err[0] != s || proto_err[0] != p) begin
      fails++;
      $display("FAIL full_tx_protocol: %0d tx_data changes, %0d starts while busy, required 0", stab_err[0] - s, proto_err[0] - p);
    end
    tests_run++;
    if (busy_w[0] !== 1'b0) begin
      fails++;
      $display("FAIL full_idle_after: busy=%b required 0", busy_w[0]);
    end
    $display("[TB] test_full_dump_msb: %0d bytes", cap_n[0] - b);
  endtask

  task automatic test_lsb_order();
    bit ok;
    int b, d, fb, errs;
    bit [7:0] first4 [4];
    first4 = '{8'h44, 8'h33, 8'h22, 8'h11};
    randomize_regs(1);
    regs[1][0] = 32'h11223344;
    rand_hold[1] = 1'b1;
    b = cap_n[1]; d = done_n[1];
    pulse_start(1);
    wait_done(1, ok);
    tests_run++;
    if (!ok || cap_n[1] - b != 128 || done_n[1] - d != 1) begin
      fails++;
      $display("FAIL lsb_count: done_seen=%0d bytes=%0d done_pulses=%0d, required 1/128/1", ok, cap_n[1] - b, done_n[1] - d);
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (cap[1][(b + i) % 1024] != first4[i]) begin
        fails++;
        $display("FAIL lsb_first_bytes[%0d]: got %h required %h", i, cap[1][(b + i) % 1024], first4[i]);
      end
    end
    errs = stream_errs(1, b, fb);
    tests_run++;
    if (errs != 0) begin
      fails++;
      $display("FAIL lsb_stream: %0d wrong bytes, first at %0d got %h required %h",
               errs, fb, cap[1][(b + fb) % 1024], exp_byte(1, fb));
    end
    $display("[TB] test_lsb_order: %0d bytes", cap_n[1] - b);
  endtask

  task automatic test_backpressure();
    bit ok, saw;
    int b, s, fb, errs;
    randomize_regs(0);
    rand_hold[0] = 1'b0;
    force_busy[0] = 1'b1;
    tick();
    b = cap_n[0]; s = stab_err[0];
    pulse_start(0);
    saw = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      // A stray tx_done while stalled in SEND must not advance the byte.
      inject_done[0] = (i == 20);
      if (bus0.tx_start === 1'b1) saw = 1'b1;
    end
    inject_done[0] = 1'b0;
    tests_run++;
    if (saw || cap_n[0] != b) begin
      fails++;
      $display("FAIL bp_stall: tx_start seen=%0d bytes=%0d while tx_busy=1, required 0/0", saw, cap_n[0] - b);
    end
    force_busy[0] = 1'b0;
    tick();
    tests_run++;
    if (bus0.tx_start !== 1'b1 || bus0.tx_data !== exp_byte(0, 0)) begin
      fails++;
      $display("FAIL bp_release: tx_start=%b tx_data=%h, required 1/%h", bus0.tx_start, bus0.tx_data, exp_byte(0, 0));
    end
    tick();
    tests_run++;
    if (bus0.tx_start !== 1'b0) begin
      fails++;
      $display("FAIL bp_single_pulse: tx_start=%b on 2nd cycle, required 0", bus0.tx_start);
    end
    wait_done(0, ok);
    errs = stream_errs(0, b, fb);
    tests_run++;
    if (!ok || cap_n[0] - b != 128 || errs != 0 || stab_err[0] != s) begin
      fails++;
      $display("FAIL bp_stream: done_seen=%0d bytes=%0d wrong=%0d first_bad=%0d tx_data_changes=%0d, required 1/128/0/-1/0",
               ok, cap_n[0] - b, errs, fb, stab_err[0] - s);
    end
    $display("[TB] test_backpressure: %0d bytes", cap_n[0] - b);
  endtask

  task automatic test_start_mid_dump();
    bit ok;
    int b, d, a, fb, errs, i;
    randomize_regs(0);
    rand_hold[0] = 1'b1;
    b = cap_n[0]; d = done_n[0]; a = ack_n[0];
    pulse_start(0);
    for (i = 0; i < 2000 && cap_n[0] - b < 40; i++) tick();
    tests_run++;
    if (cap_n[0] - b < 40) begin
      fails++;
      $display("FAIL mid_start_progress: got %0d bytes required 40", cap_n[0] - b);
    end
    pulse_start(0);
    tick();
    pulse_start(0);
    wait_done(0, ok);
    errs = stream_errs(0, b, fb);
    tests_run++;
    if (!ok || cap_n[0] - b != 128 || done_n[0] - d != 1 || done_ack[0] - a != 128) begin
      fails++;
      $display("FAIL mid_start_count: done_seen=%0d bytes=%0d done_pulses=%0d acks_at_done=%0d, required 1/128/1/128",
               ok, cap_n[0] - b, done_n[0] - d, done_ack[0] - a);
    end
    tests_run++;
    if (errs != 0) begin
      fails++;
      $display("FAIL mid_start_stream: %0d wrong bytes, first at %0d", errs, fb);
    end
    repeat (20) tick();
    tests_run++;
    if (cap_n[0] - b != 128 || done_n[0] - d != 1 || busy_w[0] !== 1'b0) begin
      fails++;
      $display("FAIL mid_start_no_queue: bytes=%0d done_pulses=%0d busy=%b, required 128/1/0",
               cap_n[0] - b, done_n[0] - d, busy_w[0]);
    end
    $display("[TB] test_start_mid_dump: %0d bytes", cap_n[0] - b);
  endtask

  task automatic test_reset_mid();
    bit ok;
    int b, c, fb, errs;
    randomize_regs(0);
    rand_hold[0] = 1'b0;
    b = cap_n[0];
    pulse_start(0);
    for (int i = 0; i < 2000 && cap_n[0] - b < 23; i++) tick();
    tests_run++;
    if (cap_n[0] - b != 23) begin
      fails++;
      $display("FAIL rmid_reach: got %0d bytes required 23 (reg 5 byte 2)", cap_n[0] - b);
    end
    rst = 1'b0;
    tick();
    tests_run++;
    if (busy_w[0] !== 1'b0 || bus0.rd_addr !== 5'd0 || bus0.tx_start !== 1'b0) begin
      fails++;
      $display("FAIL rmid_abort: busy=%b rd_addr=%0d tx_start=%b, required 0/0/0", busy_w[0], bus0.rd_addr, bus0.tx_start);
    end
    rst = 1'b1;
    c = cap_n[0];
    repeat (30) tick();
    tests_run++;
    if (cap_n[0] != c) begin
      fails++;
      $display("FAIL rmid_quiet: %0d tx_start after reset, required 0", cap_n[0] - c);
    end
    b = cap_n[0];
    pulse_start(0);
    wait_done(0, ok);
    errs = stream_errs(0, b, fb);
    tests_run++;
    if (!ok || cap_n[0] - b != 128 || errs != 0) begin
      fails++;
      $display("FAIL rmid_redump: done_seen=%0d bytes=%0d wrong=%0d first_bad=%0d, required 1/128/0/-1",
               ok, cap_n[0] - b, errs, fb);
    end
    tests_run++;
    if (cap[0][b % 1024] != exp_byte(0, 0)) begin
      fails++;
      $display("FAIL rmid_first_byte: got %h required %h", cap[0][b % 1024], exp_byte(0, 0));
    end
    $display("[TB] test_reset_mid: redump %0d bytes", cap_n[0] - b);
  endtask

  initial begin
    test_reset();
    test_full_dump_msb();
    test_lsb_order();
    test_backpressure();
    test_start_mid_dump();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
